top_soc_ram: RTL and testbench
==============================

Name: top_soc_ram

Overview:
- SoC-level top wrapping a small simple-dual-port register-file RAM: one write port and one read port, both indexed by the same address width.
- Used as the first memory building block of the RISC-V SoC and bring-up target for memory testbenches.
- Synchronous write, registered (1-cycle) read, all state cleared by reset.

Parameters:
- WORD_WIDTH, 32, data word width in bits (from shared package).
- INDEX_WIDTH, 4, address width; depth = 2**INDEX_WIDTH entries (16 by default).

Ports:
- clk_i  input  1  single clock, all state on rising edge.
- arstn_i  input  1  asynchronous, active-low reset.
- wr_i  input  1  write enable.
- wr_data_i  input  WORD_WIDTH  write data.
- wr_index_i  input  INDEX_WIDTH  write address.
- rd_i  input  1  read enable.
- rd_data_o  output  WORD_WIDTH  registered read data.
- rd_index_i  input  INDEX_WIDTH  read address.

Behaviour:
- Interface: one clock (clk_i); reset arstn_i is asynchronous and active-low.
- Reset (arstn_i=0): immediately, independent of clk_i, all entries cleared to 0 and rd_data_o = 0. Held while arstn_i low; wr_i/rd_i ignored during reset. Reset asserted mid-operation discards any in-flight read/write of that cycle.
- Write: at rising edge with wr_i=1, mem[wr_index_i] <= wr_data_i. wr_i=0: memory unchanged.
- Read: at rising edge with rd_i=1, rd_data_o <= mem[rd_index_i]; value visible one cycle after request, held until next read or reset. rd_i=0: rd_data_o holds previous value.
- Never-written (post-reset) entries read as 0.
- Simultaneous wr_i and rd_i, different indices: both performed independently in the same cycle.
- Simultaneous wr_i and rd_i, same index: read-first; rd_data_o gets the old contents, new data stored (see optional feature).
- Full index range 0..2**INDEX_WIDTH-1 valid; no out-of-range case exists; no wrap logic.
- No handshake/backpressure: every enabled request completes in one cycle.
- All X-free: inputs with wr_i=0/rd_i=0 are don't-care.

Optional Feature:
- Macro RAM_WR_BYPASS_EN.
- Defined: same-cycle read and write to the same index forward wr_data_i to rd_data_o (write-first); memory still updated.
- Undefined: read-first behaviour as above; no forwarding mux synthesized.

Decomposition:
- Shared package (RISCV_pkg): WORD_WIDTH and INDEX_WIDTH constants, plus derived DEPTH = 2**INDEX_WIDTH; word_t / index_t typedefs.
- One sub-module: ram_sdp (flop-array storage, write port, registered read port, bypass under macro); top_soc_ram instantiates it and passes ports through.

Test Plan:
- Reset then wr_i=1, index 1, data 5; next cycle rd_i=1 index 1 -> rd_data_o=5 one cycle later.
- Read index 2 (never written) after reset -> rd_data_o=0.
- Overwrite index 1 with 7, then read index 1 -> rd_data_o=7; idle cycles with rd_i=0 -> rd_data_o stays 7.
- Same-cycle write index 3 data 9 (old 0) and read index 3 -> rd_data_o=0 without macro, 9 with RAM_WR_BYPASS_EN; following read -> 9.
- Same-cycle write index 4 data 0xA and read index 1 (holding 7) -> rd_data_o=7, later read of index 4 -> 0xA.
- Assert arstn_i mid-burst between edges -> rd_data_o=0 immediately; after release, read index 1 -> 0.

Source files
------------

// File: rtl/RISCV_pkg.sv
// Shared SoC constants and typedefs for the memory building blocks.
package RISCV_pkg;

  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned DEPTH       = 2 ** INDEX_WIDTH;

  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [INDEX_WIDTH-1:0] index_t;

endpackage

// File: rtl/ram_sdp.sv
// Simple-dual-port flop-array RAM: synchronous write, registered read.
// Define RAM_WR_BYPASS_EN for write-first forwarding on same-index collisions.
module ram_sdp
  import RISCV_pkg::*;
#(
  parameter int unsigned WordWidth  = WORD_WIDTH,
  parameter int unsigned IndexWidth = INDEX_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  wr_i,
  input  logic [WordWidth-1:0]  wr_data_i,
  input  logic [IndexWidth-1:0] wr_index_i,
  input  logic                  rd_i,
  input  logic [IndexWidth-1:0] rd_index_i,
  output logic [WordWidth-1:0]  rd_data_o
);

  localparam int unsigned Depth = 2 ** IndexWidth;

  logic [WordWidth-1:0] mem_q [Depth];
  logic [WordWidth-1:0] rd_data_d, rd_data_q;

  for (genvar g = 0; g < Depth; g++) begin : g_entry
    logic wr_en;
    assign wr_en = wr_i && (wr_index_i == IndexWidth'(g));

    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        mem_q[g] <= '0;
      end else if (wr_en) begin
        mem_q[g] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_i) begin
      rd_data_d = mem_q[rd_index_i];
`ifdef RAM_WR_BYPASS_EN
      // Write-first: a colliding write wins over the stored word.
      if (wr_i && (wr_index_i == rd_index_i)) begin
        rd_data_d = wr_data_i;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/top_soc_ram.sv
// SoC-level wrapper around the simple-dual-port register-file RAM.
// Optional write-first forwarding is selected by RAM_WR_BYPASS_EN.
module top_soc_ram
  import RISCV_pkg::*;
#(
  parameter int unsigned WordWidth  = WORD_WIDTH,
  parameter int unsigned IndexWidth = INDEX_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  wr_i,
  input  logic [WordWidth-1:0]  wr_data_i,
  input  logic [IndexWidth-1:0] wr_index_i,
  input  logic                  rd_i,
  output logic [WordWidth-1:0]  rd_data_o,
  input  logic [IndexWidth-1:0] rd_index_i
);

  ram_sdp #(
    .WordWidth (WordWidth),
    .IndexWidth(IndexWidth)
  ) u_ram_sdp (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .wr_i      (wr_i),
    .wr_data_i (wr_data_i),
    .wr_index_i(wr_index_i),
    .rd_i      (rd_i),
    .rd_index_i(rd_index_i),
    .rd_data_o (rd_data_o)
  );

endmodule

// File: tb/tb_top_soc_ram.sv
// Self-checking bench for top_soc_ram: vector table driven through a scoreboard queue.
module tb_top_soc_ram;
  import RISCV_pkg::*;

  logic   clk;
  logic   arstn;
  logic   wr;
  word_t  wr_data;
  index_t wr_index;
  logic   rd;
  index_t rd_index;
  word_t  rd_data;

  int unsigned errors = 0;
  int unsigned checks = 0;

  word_t exp_q[$];

  top_soc_ram u_dut (
    .clk_i     (clk),
    .arstn_i   (arstn),
    .wr_i      (wr),
    .wr_data_i (wr_data),
    .wr_index_i(wr_index),
    .rd_i      (rd),
    .rd_data_o (rd_data),
    .rd_index_i(rd_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    logic   wr;
    index_t widx;
    word_t  wdata;
    logic   rd;
    index_t ridx;
    word_t  exp;   // rd_data_o after the edge
  } vec_t;

`ifdef RAM_WR_BYPASS_EN
  localparam word_t CollideExp = 32'd9;
`else
  localparam word_t CollideExp = 32'd0;
`endif

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr = 1'b0; rd = 1'b0;
    wr_data = '0; wr_index = '0; rd_index = '0;
  endtask

  // Drive one cycle at negedge, push its expectation, compare just after the posedge.
  task automatic step(input string name, input logic w, input index_t wi, input word_t wd,
                      input logic r, input index_t ri, input word_t exp);
    word_t e;
    @(negedge clk);
    wr = w; wr_index = wi; wr_data = wd;
    rd = r; rd_index = ri;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got %h expected entry", name, rd_data);
    end else begin
      e = exp_q.pop_front();
      check(name, rd_data, e);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"wr1_5",       1'b1, 4'd1,  32'd5,         1'b0, 4'd0,  32'd0},
      '{"rd1",         1'b0, 4'd0,  32'd0,         1'b1, 4'd1,  32'd5},
      '{"rd2_unwr",    1'b0, 4'd0,  32'd0,         1'b1, 4'd2,  32'd0},
      '{"wr1_7",       1'b1, 4'd1,  32'd7,         1'b0, 4'd0,  32'd0},
      '{"rd1_7",       1'b0, 4'd0,  32'd0,         1'b1, 4'd1,  32'd7},
      '{"hold_a",      1'b0, 4'd0,  32'd0,         1'b0, 4'd5,  32'd7},
      '{"hold_b",      1'b0, 4'd0,  32'd0,         1'b0, 4'd2,  32'd7},
      '{"collide3",    1'b1, 4'd3,  32'd9,         1'b1, 4'd3,  CollideExp},
      '{"rd3",         1'b0, 4'd0,  32'd0,         1'b1, 4'd3,  32'd9},
      '{"wr4_rd1",     1'b1, 4'd4,  32'hA,         1'b1, 4'd1,  32'd7},
      '{"rd4",         1'b0, 4'd0,  32'd0,         1'b1, 4'd4,  32'hA},
      '{"wr15_rd0",    1'b1, 4'd15, 32'hDEADBEEF,  1'b1, 4'd0,  32'd0},
      '{"rd15",        1'b0, 4'd0,  32'd0,         1'b1, 4'd15, 32'hDEADBEEF},
      '{"wr0_rd15",    1'b1, 4'd0,  32'h12345678,  1'b1, 4'd15, 32'hDEADBEEF},
      '{"rd0",         1'b0, 4'd0,  32'd0,         1'b1, 4'd0,  32'h12345678},
      '{"rd1_again",   1'b0, 4'd0,  32'd0,         1'b1, 4'd1,  32'd7}
    };

    idle_inputs();
    arstn = 1'b0;
    #3;
    check("reset_rd_data", rd_data, '0);
    @(negedge clk);
    arstn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].wr, vecs[i].widx, vecs[i].wdata,
           vecs[i].rd, vecs[i].ridx, vecs[i].exp);
    end

    // Asynchronous reset between edges with a write and read in flight.
    @(negedge clk);
    wr = 1'b1; wr_index = 4'd1; wr_data = 32'h55; rd = 1'b1; rd_index = 4'd4;
    #2;
    arstn = 1'b0;
    #1;
    check("async_rst_now", rd_data, '0);
    @(posedge clk);
    #1;
    check("rst_held_edge", rd_data, '0);
    @(negedge clk);
    idle_inputs();
    arstn = 1'b1;

    step("post_rst_rd1",  1'b0, 4'd0, 32'd0, 1'b1, 4'd1,  32'd0);
    step("post_rst_rd4",  1'b0, 4'd0, 32'd0, 1'b1, 4'd4,  32'd0);
    step("post_rst_rd15", 1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'd0);
    step("post_rst_wr2",  1'b1, 4'd2, 32'hCAFE, 1'b0, 4'd0, 32'd0);
    step("post_rst_rd2",  1'b0, 4'd0, 32'd0, 1'b1, 4'd2,  32'hCAFE);

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
